// File: rtl/pipe_skid.sv
// pipe_skid: two-entry valid/ready register slice whose in_rdy, out_vld and out_data are all registered.
// Define PIPE_SKID_STALL_CNT_EN to add a saturating stall counter (stall_clr / stall_cnt ports).
module pipe_skid #(
  parameter int unsigned  W     = 32,
  parameter logic [W-1:0] INIT  = '0,
  parameter int unsigned  CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_vld,
  input  logic [W-1:0]     in_data,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [W-1:0]     out_data,
  input  logic             out_rdy
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  input  logic             stall_clr,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic           in_rdy_r;
  logic           out_vld_r;
  logic [W-1:0]   m_r;
  logic [W-1:0]   s_r;
  logic [W-1:0]   m_nxt_s;
  logic           m_we_s;
  logic           m_from_s_s;
  logic           s_we_s;
  logic           in_xfer_s;
  logic           out_xfer_s;

  assign in_xfer_s  = in_vld && in_rdy_r;
  assign out_xfer_s = out_vld_r && out_rdy;

  // Next-state and payload write-enable decode.
  always_comb begin
    state_s    = state_r;
    m_we_s     = 1'b0;
    m_from_s_s = 1'b0;
    s_we_s     = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (in_xfer_s) begin
          state_s = ST_ONE;
          m_we_s  = 1'b1;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_xfer_s && out_xfer_s) begin
          state_s = ST_ONE;
          m_we_s  = 1'b1;
        end else if (in_xfer_s) begin
          // Downstream stalled: park the younger entry in the skid register.
          state_s = ST_TWO;
          s_we_s  = 1'b1;
        end else if (out_xfer_s) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (out_xfer_s) begin
          state_s    = ST_ONE;
          m_we_s     = 1'b1;
          m_from_s_s = 1'b1;
        end else begin
          state_s = ST_TWO;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // Main register source: skid entry on drain from TWO, otherwise upstream payload.
  always_comb begin
    m_nxt_s = in_data;
    if (m_from_s_s) begin
      m_nxt_s = s_r;
    end else begin
      m_nxt_s = in_data;
    end
  end

  // State and handshake flops; handshakes are decoded from the next state so they stay registered.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r   <= ST_EMPTY;
      in_rdy_r  <= 1'b0;
      out_vld_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_rdy_r  <= (state_s != ST_TWO);
      out_vld_r <= (state_s != ST_EMPTY);
    end
  end

  // Payload registers, written only when a transfer targets them.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_r <= INIT;
      s_r <= INIT;
    end else begin
      if (m_we_s) begin
        m_r <= m_nxt_s;
      end
      if (s_we_s) begin
        s_r <= in_data;
      end
    end
  end

  assign in_rdy   = in_rdy_r;
  assign out_vld  = out_vld_r;
  assign out_data = m_r;

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Saturating stall counter; clear wins over increment.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_r <= '0;
    end else if (stall_clr) begin
      stall_cnt_r <= '0;
    end else if (out_vld_r && !out_rdy && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  logic unused_cnt_w_s;
  assign unused_cnt_w_s = ^CNT_W;
`endif

endmodule
